// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared FSM/owner encodings and cache-line geometry
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;
  localparam int LINE_WORDS_LOG_DEF = 3;
  localparam int LINE_WORDS = 1 << LINE_WORDS_LOG_DEF;
  localparam int LINE_OFS_BITS = LINE_WORDS_LOG_DEF + 2;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin pick, a tie goes to the requester that did not own last
module rr_arbiter2
  import mem_port_arbiter_pkg::*;
(
  input  logic   req0,
  input  logic   req1,
  input  owner_t last,
  output logic   valid,
  output owner_t pick
);
  assign valid = req0 | req1;
  assign pick = (req0 & req1) ? owner_t'(~last) : (req1 ? OWN_D : OWN_I);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the memory port between ICache and DCache line bursts
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LINE_WORDS_LOG = LINE_WORDS_LOG_DEF,
  parameter int ADDR_LEN = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_req,
  input  logic [ADDR_LEN-1:0]       i_addr,
  input  logic                      d_req,
  input  logic                      d_we,
  input  logic [ADDR_LEN-1:0]       d_addr,
  input  logic [31:0]               d_wdata,
  output logic                      i_gnt,
  output logic                      d_gnt,
  output logic [LINE_WORDS_LOG-1:0] beat,
  output logic [31:0]               rdata,
  output logic                      i_rvalid,
  output logic                      d_rvalid,
  output logic                      i_done,
  output logic                      d_done,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_LEN-1:0]       mem_addr,
  output logic [31:0]               mem_wdata,
  input  logic [31:0]               mem_rdata,
  input  logic                      mem_ready
);
  localparam logic [ADDR_LEN-1:0] OFS_MASK = ADDR_LEN'((1 << (LINE_WORDS_LOG + 2)) - 1);
  state_t              state;
  owner_t              owner;
  owner_t              last_owner;
  owner_t              pick;
  logic                pick_valid;
  logic                dir;
  logic [ADDR_LEN-1:0] base;
  logic [31:0]         rdata_q;
  logic                xfer;
  logic                st_done;
  logic                rd_hit;
  rr_arbiter2 u_rr (
    .req0  (i_req),
    .req1  (d_req),
    .last  (last_owner),
    .valid (pick_valid),
    .pick  (pick)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_I;
      last_owner <= OWN_I;
      dir        <= 1'b0;
      base       <= '0;
      beat       <= '0;
      rdata_q    <= '0;
    end else begin
      case (state)
        IDLE: if (pick_valid) begin
          owner <= pick;
          dir   <= (pick == OWN_D) & d_we;
          base  <= ((pick == OWN_D) ? d_addr : i_addr) & ~OFS_MASK;
          beat  <= '0;
          state <= XFER;
        end
        XFER: if (mem_ready) begin
          rdata_q <= dir ? rdata_q : mem_rdata;
          beat    <= beat + LINE_WORDS_LOG'(1);
          state   <= &beat ? DONE : XFER;
        end
        DONE: begin
          last_owner <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign xfer      = state == XFER;
  assign st_done   = state == DONE;
  assign rd_hit    = xfer & mem_ready & ~dir;
  assign i_gnt     = (xfer | st_done) & (owner == OWN_I);
  assign d_gnt     = (xfer | st_done) & (owner == OWN_D);
  assign i_done    = st_done & (owner == OWN_I);
  assign d_done    = st_done & (owner == OWN_D);
  assign i_rvalid  = rd_hit & (owner == OWN_I);
  assign d_rvalid  = rd_hit & (owner == OWN_D);
  assign rdata     = rd_hit ? mem_rdata : rdata_q;
  assign mem_req   = xfer;
  assign mem_we    = xfer & dir;
  assign mem_addr  = xfer ? (base | (ADDR_LEN'(beat) << 2)) : '0;
  assign mem_wdata = (xfer & dir) ? d_wdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for the ICache/DCache memory-port arbiter
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;
  logic clk = 0, rst = 1, i_req = 0, d_req = 0, d_we = 0, mem_ready = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic i_gnt, d_gnt, i_rvalid, d_rvalid, i_done, d_done, mem_req, mem_we;
  logic [2:0] beat;
  logic [31:0] rdata, mem_addr, mem_wdata;
  typedef struct {logic [31:0] addr; logic we; logic [31:0] data; logic [2:0] idx; logic own;} exp_t;
  exp_t exp_q[$];
  int checks = 0, passed = 0;
  always #5 clk = ~clk;
  mem_port_arbiter dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .i_gnt(i_gnt), .d_gnt(d_gnt), .beat(beat), .rdata(rdata),
    .i_rvalid(i_rvalid), .d_rvalid(d_rvalid), .i_done(i_done), .d_done(d_done), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );
  task automatic push_line(input logic [31:0] b, input logic we, input logic own);
    for (int k = 0; k < LINE_WORDS; k++)
      exp_q.push_back('{b + 32'(4 * k), we, we ? 32'hA0 + 32'(k) : 32'h0, 3'(k), own});
  endtask
  task automatic drive(input logic rdy);
    mem_ready = rdy;
    mem_rdata = $urandom;
    d_wdata = 32'hA0 + 32'(beat);
    #1;
  endtask
  task automatic test_reset();
    repeat (2) begin @(negedge clk); drive(0); end
    checks++;
    if ({i_gnt, d_gnt, beat, rdata, i_rvalid, d_rvalid, i_done, d_done, mem_req, mem_we, mem_addr, mem_wdata} !== '0)
      $display("FAIL reset_hold: gnt=%b%b beat=%0d rdata=%h mem_req=%b mem_addr=%h, want all 0", i_gnt, d_gnt, beat, rdata, mem_req, mem_addr);
    else passed++;
    @(negedge clk); rst = 0; drive(0);
    checks++;
    if ({i_gnt, d_gnt, beat, rdata, i_rvalid, d_rvalid, i_done, d_done, mem_req, mem_we, mem_addr, mem_wdata} !== '0)
      $display("FAIL reset_release: gnt=%b%b beat=%0d rdata=%h mem_req=%b, want all 0", i_gnt, d_gnt, beat, rdata, mem_req);
    else passed++;
  endtask
  task automatic test_icache_read();
    exp_t e;
    int nb = 0, dc = 0;
    push_line(32'h1220, 0, 0);
    @(negedge clk); i_req = 1; i_addr = 32'h1234; drive(1);
    for (int c = 2; c <= 12; c++) begin
      @(negedge clk); if (c == 11) i_req = 0; drive(1);
      if (mem_req && mem_ready) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL icache_beat: unexpected beat addr=%h", mem_addr);
        else begin
          e = exp_q.pop_front();
          if ({mem_addr, mem_we, mem_wdata, beat, i_rvalid, d_rvalid} !== {e.addr, e.we, e.data, e.idx, !e.we && !e.own, !e.we && e.own} || rdata !== mem_rdata)
            $display("FAIL icache_beat: addr=%h we=%b beat=%0d rv=%b%b rdata=%h, want addr=%h we=%b beat=%0d rdata=%h", mem_addr, mem_we, beat, i_rvalid, d_rvalid, rdata, e.addr, e.we, e.idx, mem_rdata);
          else passed++;
        end
        nb++;
      end
      checks++;
      if ({i_gnt, i_done, d_gnt, d_rvalid, d_done} !== {c >= 2 && c <= 10, c == 10, 3'b000})
        $display("FAIL icache_ctl: cycle %0d gnt=%b done=%b d=%b%b%b, want gnt=%b done=%b d=000", c, i_gnt, i_done, d_gnt, d_rvalid, d_done, c >= 2 && c <= 10, c == 10);
      else passed++;
      if (i_done) dc = c;
    end
    checks++;
    if (dc != 10 || nb != 8) $display("FAIL icache_count: done at %0d beats %0d, want 10 and 8", dc, nb);
    else passed++;
  endtask
  task automatic test_tie();
    exp_t e;
    int nb = 0, dd = 0, ig = 0, id = 0;
    logic own, seen;
    d_we = 0; d_addr = 32'h4abc; i_addr = 32'h2004;
    push_line(32'h4aa0, 0, 1);
    push_line(32'h2000, 0, 0);
    @(negedge clk); i_req = 1; d_req = 1; drive(1);
    for (int c = 1; c < 40 && id == 0; c++) begin
      @(negedge clk); if (dd != 0) d_req = 0; drive(1);
      if (mem_req && mem_ready) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL tie_beat: unexpected beat addr=%h", mem_addr);
        else begin
          e = exp_q.pop_front();
          if ({mem_addr, mem_we, mem_wdata, beat, i_rvalid, d_rvalid} !== {e.addr, e.we, e.data, e.idx, !e.we && !e.own, !e.we && e.own} || rdata !== mem_rdata)
            $display("FAIL tie_beat: addr=%h beat=%0d rv=%b%b, want addr=%h beat=%0d rv_owner=%b", mem_addr, beat, i_rvalid, d_rvalid, e.addr, e.idx, e.own);
          else passed++;
        end
        nb++;
      end
      checks++;
      if (i_gnt && d_gnt) $display("FAIL tie_onehot: cycle %0d both grants high", c);
      else passed++;
      if (d_done) dd = c;
      if (i_gnt && ig == 0) ig = c;
      if (i_done) id = c;
    end
    checks++;
    if (dd != 9 || ig != 11 || id != 19 || nb != 16)
      $display("FAIL tie_order: d_done=%0d i_gnt=%0d i_done=%0d beats=%0d, want 9 11 19 16", dd, ig, id, nb);
    else passed++;
    @(negedge clk); i_req = 0; drive(1);
    for (int r = 0; r < 2; r++) begin
      own = (r == 0); seen = 0; nb = 0;
      push_line(own ? 32'h4aa0 : 32'h2000, 0, own);
      @(negedge clk); i_req = 1; d_req = 1; drive(1);
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk); drive(1);
        if (mem_req && mem_ready) begin
          checks++;
          if (exp_q.size() == 0) $display("FAIL tie_rr_beat: unexpected beat addr=%h", mem_addr);
          else begin
            e = exp_q.pop_front();
            if ({mem_addr, beat, i_rvalid, d_rvalid} !== {e.addr, e.idx, !e.own, e.own} || rdata !== mem_rdata)
              $display("FAIL tie_rr_beat: addr=%h beat=%0d rv=%b%b, want addr=%h beat=%0d owner=%b", mem_addr, beat, i_rvalid, d_rvalid, e.addr, e.idx, e.own);
            else passed++;
          end
          nb++;
        end
        checks++;
        if ((own ? {i_gnt, i_rvalid, i_done} : {d_gnt, d_rvalid, d_done}) !== 3'b000)
          $display("FAIL tie_rr_loser: round %0d loser active gnt=%b%b, want winner %b only", r, i_gnt, d_gnt, own);
        else passed++;
        if (i_done || d_done) begin
          seen = 1;
          checks++;
          if ({d_done, i_done} !== {own, !own}) $display("FAIL tie_rr_done: done=%b%b, want %b%b", d_done, i_done, own, !own);
          else passed++;
        end
      end
      checks++;
      if (!seen || nb != 8) $display("FAIL tie_rr_count: round %0d seen=%b beats=%0d, want 1 and 8", r, seen, nb);
      else passed++;
      @(negedge clk); i_req = 0; d_req = 0; drive(1);
    end
  endtask
  task automatic test_writeback();
    exp_t e;
    int nb = 0, lr = 0;
    logic seen = 0;
    d_we = 1; d_addr = 32'h8000_0040;
    push_line(32'h8000_0040, 1, 1);
    @(negedge clk); d_req = 1; drive(0);
    for (int c = 1; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (d_gnt) begin d_we = 0; d_addr = 32'h1111_1100; end
      drive(c % 3 == 0);
      if (mem_req && mem_ready) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL wb_beat: unexpected beat addr=%h", mem_addr);
        else begin
          e = exp_q.pop_front();
          if ({mem_addr, mem_we, mem_wdata, beat} !== {e.addr, e.we, e.data, e.idx})
            $display("FAIL wb_beat: addr=%h we=%b wdata=%h beat=%0d, want addr=%h we=%b wdata=%h beat=%0d", mem_addr, mem_we, mem_wdata, beat, e.addr, e.we, e.data, e.idx);
          else passed++;
        end
        nb++; lr = c;
      end
      checks++;
      if ({d_rvalid, i_gnt, i_rvalid, i_done} !== 4'b0 || (mem_req && mem_we !== 1'b1))
        $display("FAIL wb_ctl: cycle %0d d_rvalid=%b i_gnt=%b mem_req=%b mem_we=%b, want no rvalid and mem_we=1", c, d_rvalid, i_gnt, mem_req, mem_we);
      else passed++;
      if (d_done) begin
        seen = 1;
        checks++;
        if (nb != 8 || lr != c - 1) $display("FAIL wb_done: beats=%0d last_ready=%0d done=%0d, want 8 and done right after", nb, lr, c);
        else passed++;
      end
    end
    checks++;
    if (!seen) $display("FAIL wb_timeout: d_done=0, want 1");
    else passed++;
    @(negedge clk); d_req = 0; d_we = 0; drive(1);
  endtask
  task automatic test_reset_mid();
    exp_t e;
    int nb = 0;
    logic hit = 0, seen = 0;
    d_we = 0; d_addr = 32'h500;
    push_line(32'h500, 0, 1);
    @(negedge clk); d_req = 1; drive(1);
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      if (mem_req && nb == 4) begin rst = 1; drive(0); hit = 1; end
      else begin
        drive(1);
        if (mem_req && mem_ready) begin
          checks++;
          e = exp_q.pop_front();
          if ({mem_addr, beat, d_rvalid} !== {e.addr, e.idx, 1'b1}) $display("FAIL rstmid_beat: addr=%h beat=%0d, want addr=%h beat=%0d", mem_addr, beat, e.addr, e.idx);
          else passed++;
          nb++;
        end
      end
    end
    checks++;
    if (!hit) $display("FAIL rstmid_timeout: beat 4 never reached, got %0d beats", nb);
    else passed++;
    exp_q.delete();
    @(negedge clk); rst = 0; d_req = 0; drive(0);
    checks++;
    if ({i_gnt, d_gnt, beat, rdata, i_rvalid, d_rvalid, i_done, d_done, mem_req, mem_we, mem_addr, mem_wdata} !== '0)
      $display("FAIL rstmid_zero: gnt=%b%b beat=%0d rdata=%h done=%b%b mem_req=%b, want all 0", i_gnt, d_gnt, beat, rdata, i_done, d_done, mem_req);
    else passed++;
    nb = 0;
    push_line(32'h600, 0, 1);
    @(negedge clk); i_req = 1; i_addr = 32'h40; d_req = 1; d_addr = 32'h600; drive(1);
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk); drive(1);
      if (mem_req && mem_ready) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL rstmid_new_beat: unexpected beat addr=%h", mem_addr);
        else begin
          e = exp_q.pop_front();
          if ({mem_addr, beat, d_rvalid} !== {e.addr, e.idx, 1'b1} || rdata !== mem_rdata)
            $display("FAIL rstmid_new_beat: addr=%h beat=%0d d_rvalid=%b, want addr=%h beat=%0d", mem_addr, beat, d_rvalid, e.addr, e.idx);
          else passed++;
        end
        nb++;
      end
      checks++;
      if ({i_gnt, i_rvalid, i_done} !== 3'b000) $display("FAIL rstmid_owner: i_gnt=%b after reset tie, want D to win (0)", i_gnt);
      else passed++;
      if (d_done) seen = 1;
    end
    checks++;
    if (!seen || nb != 8) $display("FAIL rstmid_count: done=%b beats=%0d, want 1 and 8", seen, nb);
    else passed++;
    @(negedge clk); i_req = 0; d_req = 0; drive(1);
  endtask
  task automatic test_stall();
    exp_t e;
    int nb = 0, stall = 5;
    logic seen = 0, rdy;
    push_line(32'h3000, 0, 0);
    @(negedge clk); i_req = 1; i_addr = 32'h3010; drive(1);
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      rdy = 1;
      if (mem_req && nb == 3 && stall > 0) begin rdy = 0; stall--; end
      drive(rdy);
      if (mem_req && !rdy) begin
        checks++;
        if ({mem_addr, beat, mem_we, i_rvalid, d_rvalid} !== {32'h300C, 3'd3, 3'b000})
          $display("FAIL stall_hold: addr=%h beat=%0d we=%b rv=%b%b, want addr=0000300c beat=3 we=0 rv=00", mem_addr, beat, mem_we, i_rvalid, d_rvalid);
        else passed++;
      end
      if (mem_req && mem_ready) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL stall_beat: unexpected beat addr=%h", mem_addr);
        else begin
          e = exp_q.pop_front();
          if ({mem_addr, mem_we, beat, i_rvalid} !== {e.addr, e.we, e.idx, 1'b1} || rdata !== mem_rdata)
            $display("FAIL stall_beat: addr=%h beat=%0d i_rvalid=%b, want addr=%h beat=%0d", mem_addr, beat, i_rvalid, e.addr, e.idx);
          else passed++;
        end
        nb++;
      end
      if (i_done) seen = 1;
    end
    checks++;
    if (!seen || nb != 8 || stall != 0) $display("FAIL stall_count: done=%b beats=%0d stalls_left=%0d, want 1 8 0", seen, nb, stall);
    else passed++;
    @(negedge clk); i_req = 0; drive(1);
  endtask
  task automatic test_protocol();
    exp_t e;
    int nb = 0;
    logic seen = 0;
    d_we = 0; d_addr = 32'h700;
    push_line(32'h700, 0, 1);
    @(negedge clk); d_req = 1; drive(1);
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk); if (nb == 2) d_req = 0; drive(1);
      if (mem_req && mem_ready) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL proto_beat: unexpected beat addr=%h", mem_addr);
        else begin
          e = exp_q.pop_front();
          if ({mem_addr, beat, d_rvalid} !== {e.addr, e.idx, 1'b1} || rdata !== mem_rdata)
            $display("FAIL proto_beat: addr=%h beat=%0d d_rvalid=%b, want addr=%h beat=%0d", mem_addr, beat, d_rvalid, e.addr, e.idx);
          else passed++;
        end
        nb++;
      end
      if (d_done) seen = 1;
    end
    checks++;
    if (!seen || nb != 8) $display("FAIL proto_count: done=%b beats=%0d, want 1 and 8", seen, nb);
    else passed++;
    repeat (3) begin
      @(negedge clk); drive(1);
      checks++;
      if ({mem_req, i_gnt, d_gnt, i_done, d_done} !== 5'b0) $display("FAIL proto_idle: mem_req=%b gnt=%b%b done=%b%b, want all 0", mem_req, i_gnt, d_gnt, i_done, d_done);
      else passed++;
    end
  endtask
  initial begin
    test_reset();
    test_icache_read();
    test_tie();
    test_writeback();
    test_reset_mid();
    test_stall();
    test_protocol();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
